// File: rtl/beam_scan_controller.sv
// Steering sweep controller: walks delay_select through every direction, integrates |beam_sum|
// per direction after a settle period, then locks onto the loudest one.
module beam_scan_controller #(
  parameter int SUM_W          = 22,
  parameter int NUM_DIR        = 32,
  parameter int SETTLE_SAMPLES = 32,
  parameter int WINDOW_LOG2    = 10,
  parameter int ACC_W          = SUM_W + WINDOW_LOG2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    manual_en,
  input  logic [4:0]              manual_dir,
  input  logic                    sample_valid,
  input  logic signed [SUM_W-1:0] beam_sum,
  output logic [4:0]              delay_select,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        dir_energy,
  output logic                    dir_energy_valid,
  output logic [4:0]              best_dir,
  output logic [ACC_W-1:0]        best_energy
);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, COMPARE, LOCK} state_t;

  localparam int SET_W = $clog2(SETTLE_SAMPLES);
  localparam int CNT_W = ((SET_W > WINDOW_LOG2) ? SET_W : WINDOW_LOG2) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST    = CNT_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [4:0]       LAST_DIR    = 5'(NUM_DIR - 1);

  state_t             state_q, state_d;
  logic [4:0]         dir_idx_q, dir_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [4:0]         cand_dir_q, cand_dir_d;
  logic [ACC_W-1:0]   cand_energy_q, cand_energy_d;
  logic [4:0]         delay_select_q, delay_select_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ACC_W-1:0]   dir_energy_q, dir_energy_d;
  logic               dir_energy_valid_q, dir_energy_valid_d;
  logic [4:0]         best_dir_q, best_dir_d;
  logic [ACC_W-1:0]   best_energy_q, best_energy_d;
  logic [SUM_W-1:0]   mag;

  // Unsigned magnitude: the most negative input maps to 2^(SUM_W-1) without wrapping.
  assign mag = SUM_W'(beam_sum[SUM_W-1] ? -beam_sum : beam_sum);

  always_comb begin
    state_d            = state_q;
    dir_idx_d          = dir_idx_q;
    cnt_d              = cnt_q;
    acc_d              = acc_q;
    cand_dir_d         = cand_dir_q;
    cand_energy_d      = cand_energy_q;
    delay_select_d     = delay_select_q;
    dir_energy_d       = dir_energy_q;
    best_dir_d         = best_dir_q;
    best_energy_d      = best_energy_q;
    done_d             = 1'b0;
    dir_energy_valid_d = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          delay_select_d = manual_en ? manual_dir : best_dir_q;
          if (start && !manual_en) begin
            dir_idx_d      = '0;
            delay_select_d = '0;
            cnt_d          = '0;
            state_d        = SETTLE;
          end
        end
        SETTLE: if (sample_valid) begin
          if (cnt_q == SETTLE_LAST) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MEASURE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MEASURE: if (sample_valid) begin
          acc_d = acc_q + ACC_W'(mag);
          if (cnt_q == WIN_LAST) state_d = COMPARE;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        COMPARE: begin
          dir_energy_d       = acc_q;
          dir_energy_valid_d = 1'b1;
          // Strict compare: on a tie the earlier (lower) direction wins.
          if (dir_idx_q == '0 || acc_q > cand_energy_q) begin
            cand_dir_d    = dir_idx_q;
            cand_energy_d = acc_q;
          end
          if (dir_idx_q == LAST_DIR) begin
            state_d = LOCK;
          end else begin
            dir_idx_d      = dir_idx_q + 1'b1;
            delay_select_d = dir_idx_q + 1'b1;
            cnt_d          = '0;
            state_d        = SETTLE;
          end
        end
        LOCK: begin
          best_dir_d     = cand_dir_q;
          best_energy_d  = cand_energy_q;
          delay_select_d = cand_dir_q;
          done_d         = 1'b1;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == COMPARE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      dir_idx_q          <= '0;
      cnt_q              <= '0;
      acc_q              <= '0;
      cand_dir_q         <= '0;
      cand_energy_q      <= '0;
      delay_select_q     <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      dir_energy_q       <= '0;
      dir_energy_valid_q <= 1'b0;
      best_dir_q         <= '0;
      best_energy_q      <= '0;
    end else begin
      state_q            <= state_d;
      dir_idx_q          <= dir_idx_d;
      cnt_q              <= cnt_d;
      acc_q              <= acc_d;
      cand_dir_q         <= cand_dir_d;
      cand_energy_q      <= cand_energy_d;
      delay_select_q     <= delay_select_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
      dir_energy_q       <= dir_energy_d;
      dir_energy_valid_q <= dir_energy_valid_d;
      best_dir_q         <= best_dir_d;
      best_energy_q      <= best_energy_d;
    end
  end

  assign delay_select     = delay_select_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign dir_energy       = dir_energy_q;
  assign dir_energy_valid = dir_energy_valid_q;
  assign best_dir         = best_dir_q;
  assign best_energy      = best_energy_q;

endmodule

// File: tb/tb_beam_scan_controller.sv
// Bench for beam_scan_controller: per-direction beam levels come from a table indexed by
// delay_select; expected energies and winner come from plain arithmetic on that table.
module tb_beam_scan_controller;
  localparam int SUM_W = 22, NUM_DIR = 4, SETTLE = 2, WL = 2, ACC_W = SUM_W + WL;
  localparam int WIN = 1 << WL;
  localparam int LAT = NUM_DIR * (SETTLE + WIN + 1) + 1;
  localparam int BUDGET = 2000;

  logic clk = 0;
  logic rst, start, abort, manual_en, sample_valid;
  logic [4:0] manual_dir;
  logic signed [SUM_W-1:0] beam_sum;
  logic [4:0] delay_select, best_dir;
  logic busy, done, dir_energy_valid;
  logic [ACC_W-1:0] dir_energy, best_energy;

  logic signed [SUM_W-1:0] val [32];
  longint got [NUM_DIR];
  int n_got;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign beam_sum = val[delay_select];

  beam_scan_controller #(.SUM_W(SUM_W), .NUM_DIR(NUM_DIR), .SETTLE_SAMPLES(SETTLE),
                         .WINDOW_LOG2(WL), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .manual_en(manual_en),
    .manual_dir(manual_dir), .sample_valid(sample_valid), .beam_sum(beam_sum),
    .delay_select(delay_select), .busy(busy), .done(done), .dir_energy(dir_energy),
    .dir_energy_valid(dir_energy_valid), .best_dir(best_dir), .best_energy(best_energy));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic longint exp_energy(int d);
    longint v = longint'(val[d]);
    return WIN * (v < 0 ? -v : v);
  endfunction

  function automatic int exp_best();
    int b = 0;
    for (int d = 1; d < NUM_DIR; d++) if (exp_energy(d) > exp_energy(b)) b = d;
    return b;
  endfunction

  // Pulses start and runs to done; poke>=0 asserts start and changes manual inputs mid-sweep.
  task automatic run_sweep(input int period, input int poke, output int lat);
    int ph = 0, cyc = 0;
    bit seen = 0;
    n_got = 0; lat = -1;
    start = 1; tick(); start = 0;
    while (!seen && cyc < BUDGET) begin
      sample_valid = (ph == 0);
      ph = (ph + 1) % period;
      if (cyc == poke) begin start = 1; manual_en = 1; manual_dir = 5'd17; end
      tick(); cyc++;
      start = 0;
      if (dir_energy_valid) begin
        if (n_got < NUM_DIR) got[n_got] = dir_energy;
        n_got++;
      end
      if (done) begin seen = 1; lat = cyc; end
    end
    manual_en = 0; sample_valid = 1;
  endtask

  task automatic set_table(input int dflt, input int sel, input int sel_v);
    for (int i = 0; i < 32; i++) val[i] = SUM_W'(dflt);
    val[sel] = SUM_W'(sel_v);
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; manual_en = 0; manual_dir = 0; sample_valid = 1;
    set_table(0, 0, 0);
    repeat (3) tick();
    rst = 0;
    checks++;
    if ({delay_select, busy, done, dir_energy, dir_energy_valid, best_dir, best_energy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ds=%0d busy=%b done=%b de=%0d dev=%b bd=%0d be=%0d, required all 0",
               delay_select, busy, done, dir_energy, dir_energy_valid, best_dir, best_energy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || delay_select !== 5'd0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b ds=%0d, required 0/0", busy, delay_select);
    end
  endtask

  task automatic test_directed_sweeps();
    int lat;
    for (int sc = 0; sc < 4; sc++) begin
      case (sc)
        0, 3: set_table(10, 2, 100);
        1:    set_table(1000, 1, -2097152);
        default: set_table(5, 0, 5);
      endcase
      run_sweep(sc == 3 ? 3 : 1, -1, lat);
      checks++;
      if (sc != 3 && lat != LAT) begin
        failures++; $display("FAIL dir_latency[%0d]: got %0d, required %0d", sc, lat, LAT);
      end else if (sc == 3 && (lat < 2 * LAT || lat > 4 * LAT)) begin
        failures++; $display("FAIL gap_latency: got %0d, required about %0d", lat, 3 * LAT);
      end
      checks++;
      if (n_got != NUM_DIR) begin
        failures++; $display("FAIL dir_count[%0d]: got %0d pulses, required %0d", sc, n_got, NUM_DIR);
      end
      for (int d = 0; d < NUM_DIR; d++) begin
        checks++;
        if (got[d] != exp_energy(d)) begin
          failures++; $display("FAIL dir_energy[%0d][%0d]: got %0d, required %0d", sc, d, got[d], exp_energy(d));
        end
      end
      checks++;
      if (best_dir !== 5'(exp_best()) || best_energy !== ACC_W'(exp_energy(exp_best())) ||
          delay_select !== 5'(exp_best()) || busy !== 1'b0) begin
        failures++;
        $display("FAIL dir_best[%0d]: got bd=%0d be=%0d ds=%0d busy=%b, required bd=%0d be=%0d",
                 sc, best_dir, best_energy, delay_select, busy, exp_best(), exp_energy(exp_best()));
      end
      tick();
      checks++;
      if (delay_select !== 5'(exp_best()) || done !== 1'b0) begin
        failures++; $display("FAIL dir_hold[%0d]: got ds=%0d done=%b, required %0d/0", sc, delay_select, done, exp_best());
      end
    end
  endtask

  task automatic test_random_sweeps();
    int lat, r;
    for (int it = 0; it < 6; it++) begin
      for (int d = 0; d < 32; d++) begin
        r = $urandom_range(0, 3);
        val[d] = (r == 0) ? SUM_W'(300) : (r == 1) ? SUM_W'(-300) :
                 SUM_W'(int'($urandom_range(0, 4194303)) - 2097152);
      end
      // Start and manual changes mid-sweep must not disturb the sweep.
      run_sweep(1, (it % 2) ? 9 : -1, lat);
      checks++;
      if (lat != LAT || n_got != NUM_DIR) begin
        failures++; $display("FAIL rnd_timing[%0d]: got lat=%0d n=%0d, required %0d/%0d", it, lat, n_got, LAT, NUM_DIR);
      end
      for (int d = 0; d < NUM_DIR; d++) begin
        checks++;
        if (got[d] != exp_energy(d)) begin
          failures++; $display("FAIL rnd_energy[%0d][%0d]: got %0d, required %0d", it, d, got[d], exp_energy(d));
        end
      end
      checks++;
      if (best_dir !== 5'(exp_best()) || best_energy !== ACC_W'(exp_energy(exp_best()))) begin
        failures++;
        $display("FAIL rnd_best[%0d]: got %0d/%0d, required %0d/%0d", it, best_dir, best_energy, exp_best(), exp_energy(exp_best()));
      end
    end
  endtask

  task automatic test_abort();
    int lat, cyc = 0;
    bit saw_done = 0;
    set_table(10, 2, 100);
    run_sweep(1, -1, lat);
    start = 1; tick(); start = 0;
    while (delay_select !== 5'd2 && cyc < BUDGET) begin tick(); cyc++; end
    checks++;
    if (cyc >= BUDGET || busy !== 1'b1) begin
      failures++; $display("FAIL abort_reach: got ds=%0d busy=%b, required ds=2 busy=1", delay_select, busy);
    end
    abort = 1; tick(); abort = 0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b, required 0", busy); end
    for (int i = 0; i < 40; i++) begin tick(); if (done) saw_done = 1; end
    checks++;
    if (saw_done || best_dir !== 5'd2 || best_energy !== ACC_W'(400) || delay_select !== 5'd2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after: got done=%b bd=%0d be=%0d ds=%0d, required 0/2/400/2", saw_done, best_dir, best_energy, delay_select);
    end
  endtask

  task automatic test_manual();
    manual_en = 1; manual_dir = 5'd17; tick(); tick();
    checks++;
    if (delay_select !== 5'd17) begin failures++; $display("FAIL manual_dir: got %0d, required 17", delay_select); end
    start = 1; tick(); start = 0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || delay_select !== 5'd17 || best_dir !== 5'd2) begin
      failures++; $display("FAIL manual_start: got busy=%b ds=%0d bd=%0d, required 0/17/2", busy, delay_select, best_dir);
    end
    manual_en = 0; tick(); tick();
    checks++;
    if (delay_select !== 5'd2) begin failures++; $display("FAIL manual_release: got %0d, required 2", delay_select); end
  endtask

  task automatic test_reset_mid();
    start = 1; tick(); start = 0;
    repeat (10) tick();
    rst = 1; tick();
    checks++;
    if (best_dir !== 5'd0 || best_energy !== '0 || busy !== 1'b0 || delay_select !== 5'd0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid: got bd=%0d be=%0d busy=%b ds=%0d, required all 0", best_dir, best_energy, busy, delay_select);
    end
    rst = 0; repeat (20) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_mid_idle: got busy=%b done=%b, required 0/0", busy, done); end
  endtask

  initial begin
    test_reset();
    test_directed_sweeps();
    test_random_sweeps();
    test_abort();
    test_manual();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
